// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Forwarding / load-use hazard / flag-forwarding controller. Keeps a
//   registered shadow {valid, rd, regwrite, memread, setflag} for each of
//   FWD_DEPTH downstream stages (1=EX, 2=MEM, 3=WB, ...), so decode only
//   presents the issuing instruction's fields.
//
//   Optional feature: define HAZARD_PERF_CNT_EN to build a saturating
//   load-use stall counter; otherwise stall_count is tied to zero.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   id_valid            ID holds a real instruction
//   id_src/id_src_used  packed source addresses / per-source read enables
//   id_rd, id_regwrite  destination and its write enable
//   id_memread          instruction is a load
//   id_setflag          instruction sets flags
//   id_isbcond          instruction is B.cond
//   flush               kill the ID instruction
//   fwd_sel             per-source select, 0=regfile, k=stage k result
//   stall               hold PC/IF-ID, bubble into EX
//   flag_sel            0=flag reg, 1=EX flags, 2=MEM flags
//   stall_count         load-use stall cycle count
module fwd_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int ZERO_REG   = 31,
    parameter int NUM_SRC    = 2,
    parameter int FWD_DEPTH  = 3,
    parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]            id_src_used,
    input  logic [REG_ADDR_W-1:0]         id_rd,
    input  logic                          id_regwrite,
    input  logic                          id_memread,
    input  logic                          id_setflag,
    input  logic                          id_isbcond,
    input  logic                          flush,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
    output logic                          stall,
    output logic [1:0]                    flag_sel,
    output logic [31:0]                   stall_count
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  memread;
        logic                  setflag;
    } stage_t;

    localparam logic [REG_ADDR_W-1:0] ZR = REG_ADDR_W'(ZERO_REG);

    stage_t             stg [1:FWD_DEPTH];
    logic [NUM_SRC-1:0] ld_hit;
    logic               issue;
    logic               f1;
    logic               f2;

    // Per-source forwarding select and load-use detection.
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        logic [REG_ADDR_W-1:0] src;
        logic                  live;
        logic [SEL_W-1:0]      sel;

        assign src  = id_src[s*REG_ADDR_W +: REG_ADDR_W];
        // ZERO_REG sources never forward, which also makes a stored
        // ZERO_REG destination unmatchable.
        assign live = id_src_used[s] && (src != ZR);

        // Scan oldest to youngest so the youngest producer overwrites.
        always_comb begin
            sel = '0;
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                if (live && stg[k].valid && stg[k].regwrite && stg[k].rd == src)
                    sel = SEL_W'(k);
            end
        end

        assign ld_hit[s] = live && stg[1].valid && stg[1].regwrite &&
                           stg[1].memread && (stg[1].rd == src);
        assign fwd_sel[s*SEL_W +: SEL_W] = reset ? '0 : sel;
    end

    // Flush dominates: a killed instruction raises no stall.
    assign stall = !reset && id_valid && !flush && (|ld_hit);
    assign issue = id_valid && !stall && !flush;

    assign f1 = stg[1].valid && stg[1].setflag;
    if (FWD_DEPTH >= 2) begin : g_f2
        assign f2 = stg[2].valid && stg[2].setflag;
    end else begin : g_nof2
        assign f2 = 1'b0;
    end

    always_comb begin
        flag_sel = 2'd0;
        if (!reset && id_valid && id_isbcond) begin
            if (f1)      flag_sel = 2'd1;
            else if (f2) flag_sel = 2'd2;
        end
    end

    // Stage shadow: S[1] takes the issuing instruction or a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= FWD_DEPTH; k++) stg[k] <= '0;
        end else begin
            stg[1] <= issue ? stage_t'{1'b1, id_rd, id_regwrite, id_memread, id_setflag}
                            : '0;
            for (int k = 2; k <= FWD_DEPTH; k++) stg[k] <= stg[k-1];
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    cnt <= '0;
        else if (stall && cnt != '1)  cnt <= cnt + 32'd1;
    end

    assign stall_count = cnt;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;
    localparam int W  = 5;
    localparam int Z  = 31;
    localparam int NS = 2;
    localparam int D  = 3;
    localparam int SW = $clog2(D + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [NS*W-1:0]   id_src;
    logic [NS-1:0]     id_src_used;
    logic [W-1:0]      id_rd;
    logic              id_regwrite, id_memread, id_setflag, id_isbcond, flush;
    logic [NS*SW-1:0]  fwd_sel;
    logic              stall;
    logic [1:0]        flag_sel;
    logic [31:0]       stall_count;

    fwd_hazard_unit #(.REG_ADDR_W(W), .ZERO_REG(Z), .NUM_SRC(NS), .FWD_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_setflag(id_setflag), .id_isbcond(id_isbcond),
        .flush(flush), .fwd_sel(fwd_sel), .stall(stall), .flag_sel(flag_sel),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Reference model: a timestamped log of issued instructions. An entry
    // issued in ID at cycle t is "age" (now - t) stages downstream.
    typedef struct {
        int       ts;
        bit [4:0] rd;
        bit       rw, mr, sf;
    } rec_t;

    rec_t        log_q[$];
    int          cyc;
    longint      cnt_model;
    int          n_assert, n_fail;
    logic [31:0] obs_sel[NS];
    logic [31:0] obs_stall, obs_flag;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input bit v, input int s0, input int s1, input bit [1:0] used,
                          input int rd, input bit rw, input bit mr, input bit sf,
                          input bit bc, input bit fl);
        id_valid    = v;
        id_src      = {W'(s1), W'(s0)};
        id_src_used = used;
        id_rd       = W'(rd);
        id_regwrite = rw;
        id_memread  = mr;
        id_setflag  = sf;
        id_isbcond  = bc;
        flush       = fl;
    endtask

    // Compare one cycle against the model, then advance a clock.
    task automatic step(input string tag);
        int esel[NS];
        bit est;
        int efl;
        bit [4:0] src;
        longint ecnt;
        if (reset) begin
            log_q.delete();
            cnt_model = 0;
        end
        est = 0;
        efl = 0;
        for (int s = 0; s < NS; s++) begin
            esel[s] = 0;
            src = id_src[s*W +: W];
            if (!reset && id_src_used[s] && src != 5'(Z)) begin
                for (int a = D; a >= 1; a--)
                    foreach (log_q[i])
                        if (cyc - log_q[i].ts == a && log_q[i].rw && log_q[i].rd == src) begin
                            esel[s] = a;
                            if (a == 1 && log_q[i].mr && id_valid && !flush) est = 1;
                        end
            end
        end
        if (!reset && id_valid && id_isbcond) begin
            foreach (log_q[i]) if (log_q[i].sf && cyc - log_q[i].ts == 2 && efl == 0) efl = 2;
            foreach (log_q[i]) if (log_q[i].sf && cyc - log_q[i].ts == 1) efl = 1;
        end
`ifdef HAZARD_PERF_CNT_EN
        ecnt = cnt_model;
`else
        ecnt = 0;
`endif
        @(negedge clk);
        for (int s = 0; s < NS; s++) begin
            obs_sel[s] = 32'(fwd_sel[s*SW +: SW]);
            chk($sformatf("%s.sel%0d", tag, s), obs_sel[s], 32'(esel[s]));
        end
        obs_stall = 32'(stall);
        obs_flag  = 32'(flag_sel);
        chk({tag, ".stall"}, obs_stall, 32'(est));
        chk({tag, ".flag"}, obs_flag, 32'(efl));
        chk({tag, ".cnt"}, stall_count, ecnt[31:0]);
        @(posedge clk);
        #1;
        if (reset) begin
            log_q.delete();
            cnt_model = 0;
        end else begin
            if (id_valid && !est && !flush)
                log_q.push_back('{cyc, id_rd, id_regwrite, id_memread, id_setflag});
            if (est && cnt_model < 64'hFFFF_FFFF) cnt_model++;
        end
        cyc++;
        while (log_q.size() > 0 && cyc - log_q[0].ts > D) void'(log_q.pop_front());
    endtask

    task automatic nop(input string tag);
        set_id(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        step(tag);
    endtask

    int pool[5] = '{1, 2, 3, 4, 31};

    initial begin
        n_assert = 0; n_fail = 0; cyc = 0; cnt_model = 0;
        reset = 1'b1;
        set_id(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        step("rst");
        reset = 1'b0;
        nop("idle");

        // Forwarding distance sweep on X1.
        set_id(1, 5, 6, 2'b11, 1, 1, 0, 0, 0, 0); step("add_x1");
        set_id(1, 1, 6, 2'b11, 9, 1, 0, 0, 0, 0); step("rd_x1_d1");
        chk("tp_fwd1", obs_sel[0], 1);
        set_id(1, 1, 6, 2'b11, 9, 1, 0, 0, 0, 0); step("rd_x1_d2");
        chk("tp_fwd2", obs_sel[0], 2);
        set_id(1, 6, 1, 2'b11, 9, 1, 0, 0, 0, 0); step("rd_x1_d3");
        chk("tp_fwd3", obs_sel[1], 3);
        set_id(1, 1, 6, 2'b11, 9, 1, 0, 0, 0, 0); step("rd_x1_d4");
        chk("tp_fwd4", obs_sel[0], 0);

        // Load-use: one stall, then MEM forwarding.
        set_id(1, 7, 8, 2'b11, 2, 1, 1, 0, 0, 0); step("ldur_x2");
        set_id(1, 2, 8, 2'b11, 10, 1, 0, 0, 0, 0); step("lu_stall");
        chk("tp_lu_stall", obs_stall, 1);
        set_id(1, 2, 8, 2'b11, 10, 1, 0, 0, 0, 0); step("lu_after");
        chk("tp_lu_sel", obs_sel[0], 2);
        chk("tp_lu_nostall", obs_stall, 0);

        // Youngest producer wins.
        set_id(1, 0, 0, 2'b00, 3, 1, 0, 0, 0, 0); step("add_x3a");
        set_id(1, 0, 0, 2'b00, 3, 1, 0, 0, 0, 0); step("add_x3b");
        set_id(1, 3, 3, 2'b11, 11, 1, 0, 0, 0, 0); step("rd_x3");
        chk("tp_youngest", obs_sel[0], 1);

        // Zero register and unused sources.
        set_id(1, 0, 0, 2'b00, 31, 1, 1, 0, 0, 0); step("ld_x31");
        set_id(1, 31, 31, 2'b11, 12, 1, 0, 0, 0, 0); step("rd_x31");
        chk("tp_x31_sel", obs_sel[0], 0);
        chk("tp_x31_stall", obs_stall, 0);
        set_id(1, 0, 0, 2'b00, 4, 1, 1, 0, 0, 0); step("ld_x4");
        set_id(1, 4, 4, 2'b00, 12, 1, 0, 0, 0, 0); step("rd_x4_unused");
        chk("tp_unused", obs_sel[0], 0);

        // Flag forwarding.
        set_id(1, 1, 2, 2'b11, 13, 1, 0, 1, 0, 0); step("subs_a");
        set_id(1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0); step("bcond_1");
        chk("tp_flag1", obs_flag, 1);
        set_id(1, 1, 2, 2'b11, 13, 1, 0, 1, 0, 0); step("subs_b");
        nop("nop_f");
        set_id(1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0); step("bcond_2");
        chk("tp_flag2", obs_flag, 2);
        nop("nop_g"); nop("nop_h");
        set_id(1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0); step("bcond_0");
        chk("tp_flag0", obs_flag, 0);

        // Flush beats load-use stall.
        set_id(1, 0, 0, 2'b00, 5, 1, 1, 0, 0, 0); step("ldur_x5");
        set_id(1, 5, 0, 2'b01, 14, 1, 0, 0, 0, 1); step("lu_flush");
        chk("tp_flush_stall", obs_stall, 0);
        set_id(1, 5, 0, 2'b01, 14, 1, 0, 0, 0, 0); step("after_flush");
        chk("tp_flush_s1_bubble", obs_sel[0], 2);

        // Reset with three live producers.
        set_id(1, 0, 0, 2'b00, 6, 1, 0, 0, 0, 0); step("add_x6");
        set_id(1, 0, 0, 2'b00, 7, 1, 0, 0, 0, 0); step("add_x7");
        set_id(1, 0, 0, 2'b00, 8, 1, 1, 0, 0, 0); step("ld_x8");
        reset = 1'b1;
        set_id(1, 8, 7, 2'b11, 15, 1, 0, 0, 0, 0); step("in_reset");
        chk("tp_rst_stall", obs_stall, 0);
        reset = 1'b0;
        set_id(1, 6, 7, 2'b11, 15, 1, 0, 0, 1, 0); step("post_reset");
        chk("tp_rst_sel0", obs_sel[0], 0);
        chk("tp_rst_sel1", obs_sel[1], 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            set_id($urandom_range(0, 9) < 8,
                   pool[$urandom_range(0, 4)], pool[$urandom_range(0, 4)],
                   2'($urandom_range(0, 3)), pool[$urandom_range(0, 4)],
                   $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                   $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                   $urandom_range(0, 9) == 0);
            step("rand");
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard controller for the pipelined CPU core, successor to the combinational operand-forwarding unit. It keeps its own registered shadow of each downstream stage's destination tag, so the decode stage presents only the issuing instruction's fields. From those it produces:

- Per-source forwarding selects across a configurable number of bypass stages.
- A load-use stall.
- Condition-flag forwarding for B.cond.

It sits beside the ID/EX pipeline register and drives the ALU operand muxes and the flag mux.

## Interface
Parameters:
- REG_ADDR_W, 5, register address width
- ZERO_REG, 31, hardwired-zero register index; never forwarded
- NUM_SRC, 2, source operands per instruction
- FWD_DEPTH, 3, bypass stages tracked (1=EX, 2=MEM, 3=WB, …); legal range 1–7
- SEL_W, $clog2(FWD_DEPTH+1), derived select width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- id_valid  in  1  ID holds a real instruction
- id_src  in  NUM_SRC*REG_ADDR_W  source register addresses; source s occupies bits [s*REG_ADDR_W +: REG_ADDR_W]
- id_src_used  in  NUM_SRC  source s is actually read
- id_rd  in  REG_ADDR_W  destination register
- id_regwrite  in  1  instruction writes id_rd
- id_memread  in  1  instruction is a load
- id_setflag  in  1  instruction sets flags (ADDS/SUBS)
- id_isbcond  in  1  instruction is B.cond
- flush  in  1  kill the ID instruction (branch taken)
- fwd_sel  out  NUM_SRC*SEL_W  per-source select: 0=register file, k=stage k result
- stall  out  1  hold PC and IF/ID; inject bubble into EX
- flag_sel  out  2  0=flag register, 1=EX ALU flags, 2=MEM-stage flags
- stall_count  out  32  load-use stall cycles (see Configuration)

## Operation
- State: FWD_DEPTH stage entries S[1..FWD_DEPTH]. Each entry holds {valid, rd, regwrite, memread, setflag}.
- Shift each clock:
  - S[k] <= S[k-1] for k ≥ 2.
  - S[1] <= ID fields with valid=1 when id_valid & !stall & !flush.
  - Otherwise S[1] <= bubble: valid=0, all flags 0.
- Match(k,s) = S[k].valid & S[k].regwrite & S[k].rd == src_s.
- fwd_sel[s]:
  - 0 if !id_src_used[s] or src_s == ZERO_REG.
  - Otherwise the smallest k with Match(k,s), so the youngest producer wins.
  - 0 if no stage matches.
- stall = id_valid & !flush & OR over s of (id_src_used[s] & src_s != ZERO_REG & Match(1,s) & S[1].memread).
- fwd_sel is still computed normally during a stall (value 1 for the load source). The datapath ignores it because EX receives a bubble.
- flag_sel is 0 unless id_valid & id_isbcond. When it is not 0:
  - 1 if S[1].valid & S[1].setflag.
  - Else 2 if S[2].valid & S[2].setflag (only when FWD_DEPTH ≥ 2).
  - Else 0.
- flush overrides stall. The killed instruction never enters S[1] and raises no stall.
- A destination of ZERO_REG is stored as written but can never match, because ZERO_REG sources are excluded.

## Timing
- fwd_sel, stall, flag_sel are combinational from ID inputs and registered S[]. They are valid in the same cycle, with zero latency.
- A load's dependent gets exactly one stall cycle. In the next cycle the load sits in S[2], giving fwd_sel=2 and stall=0.
- reset mid-operation: all S[].valid=0 and stall_count=0 immediately. While reset is high, outputs are stall=0, fwd_sel=0, flag_sel=0.
- Simultaneous matches across stages resolve to the lowest k. Simultaneous stall and flush resolve to stall=0 with a bubble in S[1].

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_count increments by 1 on every rising edge where stall=1.
  - It saturates at 32'hFFFF_FFFF.
  - It is cleared only by reset.
- HAZARD_PERF_CNT_EN undefined: no counter register; stall_count is tied to 32'd0.

## Test plan
- ADD X1 issued, then SUB reading X1 next cycle -> fwd_sel[0]=1. Two cycles later, a reader of X1 gets fwd_sel=2. Three cycles later it gets 3. Four cycles later it gets 0.
- LDUR X2 followed by ADD reading X2 -> stall=1 for one cycle, S[1] bubble. Next cycle fwd_sel=2, stall=0, and stall_count=1 with the macro, 0 without.
- ADD X3 then ADD X3 then reader of X3 -> fwd_sel=1 (youngest wins, not 2).
- Source = X31, with X31 also in S[1] as a regwrite destination -> fwd_sel=0, stall=0. Same when id_src_used=0 for a matching register.
- SUBS then B.cond -> flag_sel=1. SUBS, NOP, B.cond -> flag_sel=2. B.cond with no setter -> 0.
- Load-use dependent with flush=1 -> stall=0, next S[1] invalid. Assert reset with 3 valid entries -> next ID reader of any of their destinations gets fwd_sel=0.
